// File: rtl/arb_stream_mux.sv
// rtl/arb_stream_mux.sv - NUM_CH-to-1 stream mux with registered output; define ARB_STREAM_MUX_RR_EN for round-robin, else fixed priority
module arb_stream_mux #(
    parameter int BUS_WIDTH = 8,
    parameter int NUM_CH    = 4,
    parameter int SEL_W     = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CH*BUS_WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]           in_valid,
    output logic [NUM_CH-1:0]           in_ready,
    input  logic                        mode,
    input  logic [SEL_W-1:0]            sel,
    output logic [BUS_WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]            out_ch,
    output logic                        out_valid,
    input  logic                        out_ready
);

    logic                 load_en;
    logic                 accept;
    logic [NUM_CH-1:0]    grant;
    logic [SEL_W-1:0]     grant_idx;
    logic [BUS_WIDTH-1:0] grant_data;
    int                   best;
`ifdef ARB_STREAM_MUX_RR_EN
    logic [SEL_W-1:0]     rr_ptr;
    int                   best_dist;
    int                   dist;
`endif

    always_comb begin
        grant      = '0;
        grant_idx  = '0;
        grant_data = '0;
        best       = -1;
`ifdef ARB_STREAM_MUX_RR_EN
        best_dist  = NUM_CH;
        dist       = 0;
`endif
        if (mode) begin
            // Out-of-range sel never matches any channel, so it yields no grant.
            for (int j = 0; j < NUM_CH; j++) begin
                if (SEL_W'(j) == sel && in_valid[j]) best = j;
            end
        end else begin
`ifdef ARB_STREAM_MUX_RR_EN
            // Winner is the valid channel at the smallest upward distance from rr_ptr.
            for (int j = 0; j < NUM_CH; j++) begin
                dist = (j + NUM_CH - int'(rr_ptr)) % NUM_CH;
                if (in_valid[j] && dist < best_dist) begin
                    best_dist = dist;
                    best      = j;
                end
            end
`else
            for (int j = NUM_CH - 1; j >= 0; j--) begin
                if (in_valid[j]) best = j;
            end
`endif
        end
        for (int j = 0; j < NUM_CH; j++) begin
            if (j == best) begin
                grant[j]   = 1'b1;
                grant_idx  = SEL_W'(j);
                grant_data = in_data[j*BUS_WIDTH +: BUS_WIDTH];
            end
        end
    end

    assign load_en  = !out_valid || out_ready;
    assign in_ready = (rst_n && load_en) ? grant : '0;
    assign accept   = |in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
        end else if (load_en) begin
            out_valid <= accept;
            if (accept) begin
                out_data <= grant_data;
                out_ch   <= grant_idx;
            end
        end
    end

`ifdef ARB_STREAM_MUX_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (accept && !mode) begin
            rr_ptr <= SEL_W'((int'(grant_idx) + 1) % NUM_CH);
        end
    end
`endif

endmodule

// File: tb/tb_arb_stream_mux.sv
// tb/tb_arb_stream_mux.sv - randomized and directed checks of arb_stream_mux against a behavioural model
module tb_arb_stream_mux;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic           mode;
    logic [1:0]     sel;
    logic [W-1:0]   out_data;
    logic [1:0]     out_ch;
    logic           out_valid;
    logic           out_ready;

    int checks = 0;
    int errors = 0;

    // Model state: contents of the output register and the arbitration pointer.
    logic         m_valid;
    logic [W-1:0] m_data;
    int           m_ch;
    int           m_ptr;

    arb_stream_mux #(.BUS_WIDTH(W), .NUM_CH(N), .SEL_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
        .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_grant(input logic [N-1:0] v, input logic m,
                                       input logic [1:0] s, input int ptr);
        if (m) return (int'(s) < N && v[s]) ? int'(s) : -1;
        for (int k = 0; k < N; k++) begin
`ifdef ARB_STREAM_MUX_RR_EN
            int c = (ptr + k) % N;
`else
            int c = k;
`endif
            if (v[c]) return c;
        end
        return -1;
    endfunction

    // Drive inputs just after a falling edge, check in_ready, clock once, check the register.
    task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic m,
                        input logic [1:0] s, input logic ordy);
        int g;
        logic load;
        logic [N-1:0] exp_rdy;
        in_valid  = v;
        in_data   = d;
        mode      = m;
        sel       = s;
        out_ready = ordy;
        #1;
        load    = !m_valid || ordy;
        g       = model_grant(v, m, s, m_ptr);
        exp_rdy = (load && g >= 0) ? N'(1 << g) : '0;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        if (load) begin
            if (g >= 0) begin
                m_valid = 1'b1;
                m_data  = d[g*W +: W];
                m_ch    = g;
                if (!m) m_ptr = (g + 1) % N;
            end else begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_data",  32'(out_data),  32'(m_data));
        chk("out_ch",    32'(out_ch),    32'(m_ch));
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        m_valid = 1'b0;
        m_data  = '0;
        m_ch    = 0;
        m_ptr   = 0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        mode      = 1'b0;
        sel       = '0;
        out_ready = 1'b0;
        m_valid   = 1'b0;
        m_data    = '0;
        m_ch      = 0;
        m_ptr     = 0;
        #1;
        chk("init_out_valid", 32'(out_valid), 32'd0);
        chk("init_in_ready",  32'(in_ready),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset mid-transfer with a word held, then all channels valid: ch0 first.
        step(4'b0100, 32'h00AA_0000, 1'b0, 2'd0, 1'b0);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        do_reset();
        step(4'b1111, 32'hA3A2_A1A0, 1'b0, 2'd0, 1'b1);
        chk("post_rst_ch", 32'(out_ch), 32'd0);

`ifdef ARB_STREAM_MUX_RR_EN
        for (int i = 0; i < 4; i++) begin
            step(4'b1111, 32'hA3A2_A1A0, 1'b0, 2'd0, 1'b1);
            chk("rr_seq", 32'(out_ch), 32'((i + 1) % 4));
        end
        do_reset();
        step(4'b0100, 32'h0022_0000, 1'b0, 2'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(4'b1001, 32'h3300_0011, 1'b0, 2'd0, 1'b1);
            chk("wrap_seq", 32'(out_ch), (i == 1) ? 32'd0 : 32'd3);
        end
`else
        for (int i = 0; i < 3; i++) begin
            step(4'b1010, 32'h3300_1100, 1'b0, 2'd0, 1'b1);
            chk("fixed_ch1", 32'(out_ch), 32'd1);
        end
        step(4'b1000, 32'h3300_1100, 1'b0, 2'd0, 1'b1);
        chk("fixed_ch3", 32'(out_ch), 32'd3);
`endif

        // Backpressure: 0x5A held for five stalled cycles, then reload on release.
        step(4'b0001, 32'h0000_005A, 1'b0, 2'd0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(4'b1111, 32'h1234_5678 + 32'(i), 1'b0, 2'd0, 1'b0);
            chk("bp_data", 32'(out_data), 32'h5A);
        end
        step(4'b0010, 32'h0000_6600, 1'b0, 2'd0, 1'b1);
        chk("bp_release", 32'(out_data), 32'h66);

        // Manual select of ch2, then ch2 idle so the register drains.
        step(4'b1111, 32'h113C_2233, 1'b1, 2'd2, 1'b1);
        chk("man_data", 32'(out_data), 32'h3C);
        chk("man_ch",   32'(out_ch),   32'd2);
        step(4'b1011, 32'h113C_2233, 1'b1, 2'd2, 1'b1);
        chk("man_drain", 32'(out_valid), 32'd0);

        for (int i = 0; i < 400; i++) begin
            step(N'($urandom), $urandom, ($urandom_range(0, 3) == 0),
                 2'($urandom), ($urandom_range(0, 3) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/arb_stream_mux.md
ARB_STREAM_MUX -- requirements
Module: arb_stream_mux

Interface
REQ-001 The block SHALL have parameter BUS_WIDTH, default 8, meaning the data width per channel in bits.
REQ-002 The block SHALL have parameter NUM_CH, default 4, meaning the number of input channels (2..16).
REQ-003 The block SHALL have parameter SEL_W, default 2, meaning the select and channel-index width; SEL_W SHALL equal clog2(NUM_CH).
REQ-004 clk  input  1  Sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  Reset, asynchronous, active-low.
REQ-006 in_data  input  NUM_CH*BUS_WIDTH  Channel i occupies bits [i*BUS_WIDTH +: BUS_WIDTH].
REQ-007 in_valid  input  NUM_CH  Per-channel valid.
REQ-008 in_ready  output  NUM_CH  Per-channel ready; combinational.
REQ-009 mode  input  1  0 = arbitrated, 1 = manual select.
REQ-010 sel  input  SEL_W  Channel used when mode=1.
REQ-011 out_data  output  BUS_WIDTH  Registered output word.
REQ-012 out_ch  output  SEL_W  Registered index of the source channel of out_data.
REQ-013 out_valid  output  1  Output register holds a word.
REQ-014 out_ready  input  1  Downstream accept.

Function
REQ-015 Transfer rule: a word SHALL move when valid and ready are both high on a rising edge, on both sides.
REQ-016 Load enable: load_en SHALL be (!out_valid || out_ready).
REQ-017 in_ready: in_ready[i] SHALL be load_en && grant[i]; at most one bit SHALL be high.
REQ-018 in_ready independence: in_ready SHALL NOT depend on in_valid of the granted channel, except through grant selection.
REQ-019 Grant, mode=0: grant SHALL go to the first asserted in_valid searching upward from rr_ptr, wrapping NUM_CH-1 to 0.
REQ-020 Grant, mode=1: grant SHALL go to channel sel only when in_valid[sel]=1; no grant when sel >= NUM_CH.
REQ-021 No requesters: when no channel is valid or eligible, grant SHALL be all zero.
REQ-022 Load: on an accepted input, out_data SHALL take the granted channel's word, out_ch SHALL take its index, and out_valid SHALL become 1.
REQ-023 Latency SHALL be exactly one cycle from input accept to out_valid.
REQ-024 Drain: when out_valid && out_ready and there is no new input accept, out_valid SHALL become 0; out_data and out_ch SHALL hold their values.
REQ-025 Back-to-back: a simultaneous output drain and new input accept SHALL reload the register in the same cycle, sustaining one word per cycle.
REQ-026 Stall: when out_valid && !out_ready, out_data, out_ch and out_valid SHALL remain stable and all in_ready SHALL be 0.
REQ-027 rr_ptr SHALL update to (granted index + 1) mod NUM_CH only on an input accept in mode=0.
REQ-028 rr_ptr SHALL be unchanged in mode=1.
REQ-029 A mode or sel change SHALL take effect on the next grant evaluation and SHALL NOT alter a word already in the output register.

Reset
REQ-030 While rst_n=0, out_valid, out_data, out_ch and rr_ptr SHALL be 0 immediately, independent of clk.
REQ-031 While rst_n=0, in_ready SHALL be forced to 0.
REQ-032 A word held at reset assertion SHALL be discarded.
REQ-033 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-034 Macro ARB_STREAM_MUX_RR_EN SHALL select the arbitration scheme for mode=0.
REQ-035 With ARB_STREAM_MUX_RR_EN defined, mode=0 SHALL use round-robin as REQ-019 and REQ-027.
REQ-036 Without ARB_STREAM_MUX_RR_EN, mode=0 SHALL use fixed priority, with the lowest valid index winning; rr_ptr SHALL be absent or constant 0.
REQ-037 mode=1 behaviour SHALL be identical with and without ARB_STREAM_MUX_RR_EN.

Verification
REQ-038 Reset: assert rst_n=0 mid-transfer with out_valid=1 -> out_valid=0, out_data=0x00 and in_ready=0000 immediately; first accept after release comes from ch0 when all channels are valid.
REQ-039 Round-robin (RR_EN): all 4 channels valid with data 0xA0..0xA3, out_ready=1 -> out_ch sequence 0,1,2,3,0 on consecutive cycles with one word per cycle.
REQ-040 Fixed priority (no RR_EN): channels 1 and 3 valid, out_ready=1 -> ch1 only is accepted until in_valid[1] drops, then ch3.
REQ-041 Backpressure: hold out_ready=0 for 5 cycles with out_valid=1 and data 0x5A -> out_data stays 0x5A, in_ready=0000; on release, next word loads on the same edge.
REQ-042 Manual mode: mode=1, sel=2, ch2 data 0x3C valid -> out_data=0x3C, out_ch=2 after 1 cycle; sel=2 with in_valid[2]=0 -> no accept, out_valid falls after drain.
REQ-043 Wrap: rr_ptr=3, only ch0 and ch3 valid -> ch3 granted first, then ch0, then ch3.
